key_action_ctrl: RTL and testbench

- Sits between the PS/2 keyboard driver (6-bit `keys` level vector) and the game-logic frame update.
- Turns raw key levels into per-frame action flags:
  - direction with last-pressed-wins arbitration;
  - latched jump start/release events, so no tap is lost between frame ticks;
  - shoot with auto-repeat;
  - hold-to-restart.
- All outputs update once per `frame_tick` and stay stable for the whole frame.

---
 rtl/key_action_ctrl_pkg.sv | 46 ++++
 rtl/key_action_ctrl_evt_latch.sv | 38 +++
 rtl/key_action_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_key_action_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/key_action_ctrl_pkg.sv
// Shared definitions for the keyboard path: key bit positions, direction codes
// and the small enums used by the action controller and its event latches.
package key_action_ctrl_pkg;

    localparam int KEY_SPACE = 5;
    localparam int KEY_R     = 4;
    localparam int KEY_W     = 3;
    localparam int KEY_S     = 2;
    localparam int KEY_A     = 1;
    localparam int KEY_D     = 0;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;

    typedef enum logic [1:0] {
        LAST_NONE  = 2'b00,
        LAST_LEFT  = 2'b01,
        LAST_RIGHT = 2'b10
    } last_dir_e;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_sel_e;

    // A single held key wins outright; with both held the most recent press decides.
    function automatic logic [1:0] resolve_dir(input logic a_held, input logic d_held,
                                               input last_dir_e last);
        logic [1:0] dir;
        dir = DIR_NONE;
        if (a_held && !d_held) begin
            dir = DIR_LEFT;
        end else if (d_held && !a_held) begin
            dir = DIR_RIGHT;
        end else if (a_held && d_held) begin
            if (last == LAST_LEFT) begin
                dir = DIR_LEFT;
            end else if (last == LAST_RIGHT) begin
                dir = DIR_RIGHT;
            end
        end
        return dir;
    endfunction

endpackage

// File: rtl/key_action_ctrl_evt_latch.sv
// Edge detector with a sticky pending bit; the pending output already folds in
// an edge from the current cycle so a consumer sampling now does not miss it.
module key_evt_latch
    import key_action_ctrl_pkg::*;
#(
    parameter edge_sel_e EDGE_SEL = EDGE_RISE
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    input  logic consume,
    output logic evt,
    output logic pend
);

    logic lvl_q;
    logic lvl_d;
    logic pend_q;
    logic pend_d;

    always_comb begin
        lvl_d  = lvl;
        evt    = (EDGE_SEL == EDGE_RISE) ? (lvl & ~lvl_q) : (~lvl & lvl_q);
        pend   = pend_q | evt;
        pend_d = consume ? 1'b0 : pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            lvl_q  <= lvl_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/key_action_ctrl.sv
// Converts raw key levels into per-frame action flags for the game logic.
// All flags are registered on frame_tick and held until the next tick.
module key_action_ctrl
    import key_action_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY   = 20,
    parameter int REPEAT_PERIOD  = 4,
    parameter int RESTART_FRAMES = 30,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] keys,
    input  logic       frame_tick,
    output logic       upd,
    output logic [1:0] dir,
    output logic       jump_start,
    output logic       jump_hold,
    output logic       jump_release,
    output logic       shoot,
    output logic       restart
);

    localparam logic [CNT_W-1:0] DELAY_C   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] RESTART_C = CNT_W'(RESTART_FRAMES);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic j_lvl;
    logic jp_evt;
    logic jr_evt;
    logic sp_evt;
    logic a_rise;
    logic d_rise;
    logic jr_consume;
    logic unused_jp_edge;
    logic unused_jr_edge;
    logic unused_sp_edge;
    logic unused_a_pend;
    logic unused_d_pend;

    assign j_lvl = keys[KEY_SPACE] | keys[KEY_W];

    // A release is only delivered on a tick that is not already delivering a start.
    assign jr_consume = frame_tick & ~jp_evt;

    key_evt_latch #(.EDGE_SEL(EDGE_RISE)) u_jump_rise (
        .clk     (clk),
        .rst     (rst),
        .lvl     (j_lvl),
        .consume (frame_tick),
        .evt     (unused_jp_edge),
        .pend    (jp_evt)
    );

    key_evt_latch #(.EDGE_SEL(EDGE_FALL)) u_jump_fall (
        .clk     (clk),
        .rst     (rst),
        .lvl     (j_lvl),
        .consume (jr_consume),
        .evt     (unused_jr_edge),
        .pend    (jr_evt)
    );

    key_evt_latch #(.EDGE_SEL(EDGE_RISE)) u_shoot_rise (
        .clk     (clk),
        .rst     (rst),
        .lvl     (keys[KEY_S]),
        .consume (frame_tick),
        .evt     (unused_sp_edge),
        .pend    (sp_evt)
    );

    key_evt_latch #(.EDGE_SEL(EDGE_RISE)) u_left_rise (
        .clk     (clk),
        .rst     (rst),
        .lvl     (keys[KEY_A]),
        .consume (1'b1),
        .evt     (a_rise),
        .pend    (unused_a_pend)
    );

    key_evt_latch #(.EDGE_SEL(EDGE_RISE)) u_right_rise (
        .clk     (clk),
        .rst     (rst),
        .lvl     (keys[KEY_D]),
        .consume (1'b1),
        .evt     (d_rise),
        .pend    (unused_d_pend)
    );

    last_dir_e        last_q, last_d;
    logic             upd_q, upd_d;
    logic [1:0]       dir_q, dir_d;
    logic             jump_start_q, jump_start_d;
    logic             jump_hold_q, jump_hold_d;
    logic             jump_release_q, jump_release_d;
    logic             shoot_q, shoot_d;
    logic             restart_q, restart_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        last_d         = last_q;
        upd_d          = frame_tick;
        dir_d          = dir_q;
        jump_start_d   = jump_start_q;
        jump_hold_d    = jump_hold_q;
        jump_release_d = jump_release_q;
        shoot_d        = shoot_q;
        restart_d      = restart_q;
        rep_cnt_d      = rep_cnt_q;
        hold_cnt_d     = hold_cnt_q;

        // Simultaneous A and D presses give no ordering information.
        if (a_rise && !d_rise) begin
            last_d = LAST_LEFT;
        end else if (d_rise && !a_rise) begin
            last_d = LAST_RIGHT;
        end

        if (frame_tick) begin
            jump_start_d   = 1'b0;
            jump_release_d = 1'b0;
            if (jp_evt) begin
                jump_start_d = 1'b1;
            end else if (jr_evt) begin
                jump_release_d = 1'b1;
            end
            jump_hold_d = j_lvl;

            dir_d = resolve_dir(keys[KEY_A], keys[KEY_D], last_d);

            shoot_d = 1'b0;
            if (sp_evt) begin
                shoot_d   = 1'b1;
                rep_cnt_d = DELAY_C;
            end else if (keys[KEY_S] && (rep_cnt_q != '0)) begin
                rep_cnt_d = rep_cnt_q - ONE_C;
                if (rep_cnt_q == ONE_C) begin
                    shoot_d   = 1'b1;
                    rep_cnt_d = PERIOD_C;
                end
            end
            if (!keys[KEY_S]) begin
                rep_cnt_d = '0;
            end

            restart_d = 1'b0;
            if (keys[KEY_R]) begin
                if (hold_cnt_q < RESTART_C) begin
                    hold_cnt_d = hold_cnt_q + ONE_C;
                    restart_d  = ((hold_cnt_q + ONE_C) == RESTART_C);
                end
            end else begin
                hold_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q         <= LAST_NONE;
            upd_q          <= 1'b0;
            dir_q          <= DIR_NONE;
            jump_start_q   <= 1'b0;
            jump_hold_q    <= 1'b0;
            jump_release_q <= 1'b0;
            shoot_q        <= 1'b0;
            restart_q      <= 1'b0;
            rep_cnt_q      <= '0;
            hold_cnt_q     <= '0;
        end else begin
            last_q         <= last_d;
            upd_q          <= upd_d;
            dir_q          <= dir_d;
            jump_start_q   <= jump_start_d;
            jump_hold_q    <= jump_hold_d;
            jump_release_q <= jump_release_d;
            shoot_q        <= shoot_d;
            restart_q      <= restart_d;
            rep_cnt_q      <= rep_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign upd          = upd_q;
    assign dir          = dir_q;
    assign jump_start   = jump_start_q;
    assign jump_hold    = jump_hold_q;
    assign jump_release = jump_release_q;
    assign shoot        = shoot_q;
    assign restart      = restart_q;

endmodule

// File: tb/tb_key_action_ctrl.sv
// Self-checking bench for key_action_ctrl: directed vector table, hand-written
// shoot/restart sequences and random key traffic against a frame-level model.
module tb_key_action_ctrl;

    localparam int RD = 20;
    localparam int RP = 4;
    localparam int RF = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] keys = 6'b0;
    logic       frame_tick = 1'b0;

    logic       upd, jump_start, jump_hold, jump_release, shoot, restart;
    logic [1:0] dir;
    logic       upd_nr, jump_start_nr, jump_hold_nr, jump_release_nr, shoot_nr, restart_nr;
    logic [1:0] dir_nr;

    always #5 clk = ~clk;

    key_action_ctrl dut (
        .clk(clk), .rst(rst), .keys(keys), .frame_tick(frame_tick),
        .upd(upd), .dir(dir), .jump_start(jump_start), .jump_hold(jump_hold),
        .jump_release(jump_release), .shoot(shoot), .restart(restart)
    );

    key_action_ctrl #(.REPEAT_DELAY(0)) dut_nr (
        .clk(clk), .rst(rst), .keys(keys), .frame_tick(frame_tick),
        .upd(upd_nr), .dir(dir_nr), .jump_start(jump_start_nr), .jump_hold(jump_hold_nr),
        .jump_release(jump_release_nr), .shoot(shoot_nr), .restart(restart_nr)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Frame-level reference model: counts presses, remembers pending releases,
    // counts held frames since a shoot press and consecutive R ticks.
    logic [5:0] m_prev;
    int         m_jp_cnt;
    bit         m_jr_pend;
    bit         m_s_press;
    bit         m_s_act[2];
    int         m_s_k[2];
    int         m_md[2] = '{RD, 0};
    int         m_r_cnt;
    int         m_last;
    logic       m_upd, m_js, m_jh, m_jr, m_rs;
    logic       m_sh[2];
    logic [1:0] m_dir;

    task automatic model_edge(input logic [5:0] k, input logic t, input logic r);
        bit j, pj, a, d, fire;
        if (r) begin
            m_prev = '0; m_jp_cnt = 0; m_jr_pend = 0; m_s_press = 0;
            m_s_act[0] = 0; m_s_act[1] = 0; m_s_k[0] = 0; m_s_k[1] = 0;
            m_r_cnt = 0; m_last = 0;
            m_upd = 0; m_js = 0; m_jh = 0; m_jr = 0; m_rs = 0; m_dir = 2'b00;
            m_sh[0] = 0; m_sh[1] = 0;
            return;
        end
        j  = k[5] | k[3];
        pj = m_prev[5] | m_prev[3];
        if (j && !pj) m_jp_cnt++;
        if (!j && pj) m_jr_pend = 1;
        if (k[2] && !m_prev[2]) m_s_press = 1;
        a = k[1] && !m_prev[1];
        d = k[0] && !m_prev[0];
        if (a && !d) m_last = 1;
        else if (d && !a) m_last = 2;
        m_upd = t;
        if (t) begin
            m_js = 0; m_jr = 0;
            if (m_jp_cnt > 0) begin m_js = 1; m_jp_cnt = 0; end
            else if (m_jr_pend) begin m_jr = 1; m_jr_pend = 0; end
            m_jh = j;
            if (k[1] && !k[0]) m_dir = 2'b10;
            else if (k[0] && !k[1]) m_dir = 2'b01;
            else if (k[0] && k[1]) m_dir = (m_last == 1) ? 2'b10 : (m_last == 2) ? 2'b01 : 2'b00;
            else m_dir = 2'b00;
            for (int i = 0; i < 2; i++) begin
                fire = 0;
                if (m_s_press) begin
                    fire = 1; m_s_act[i] = k[2]; m_s_k[i] = 0;
                end else if (k[2] && m_s_act[i]) begin
                    m_s_k[i]++;
                    fire = (m_md[i] > 0) && (m_s_k[i] >= m_md[i]) && ((m_s_k[i] - m_md[i]) % RP == 0);
                end
                if (!k[2]) m_s_act[i] = 0;
                m_sh[i] = fire;
            end
            m_s_press = 0;
            if (k[4]) begin m_r_cnt++; m_rs = (m_r_cnt == RF); end
            else begin m_r_cnt = 0; m_rs = 0; end
        end
        m_prev = k;
    endtask

    task automatic step(input logic [5:0] k, input logic t, input logic r);
        @(negedge clk);
        keys = k; frame_tick = t; rst = r;
        @(posedge clk);
        model_edge(k, t, r);
        #1;
        chk("upd", {7'b0, upd}, {7'b0, m_upd});
        chk("dir", {6'b0, dir}, {6'b0, m_dir});
        chk("jump_start", {7'b0, jump_start}, {7'b0, m_js});
        chk("jump_hold", {7'b0, jump_hold}, {7'b0, m_jh});
        chk("jump_release", {7'b0, jump_release}, {7'b0, m_jr});
        chk("shoot", {7'b0, shoot}, {7'b0, m_sh[0]});
        chk("restart", {7'b0, restart}, {7'b0, m_rs});
        chk("nr_upd", {7'b0, upd_nr}, {7'b0, m_upd});
        chk("nr_shoot", {7'b0, shoot_nr}, {7'b0, m_sh[1]});
    endtask

    typedef struct {
        logic [5:0] k;
        logic       t;
        logic       r;
        logic       c;
        logic       upd;
        logic [1:0] dir;
        logic       js;
        logic       jh;
        logic       jr;
    } vec_t;

    vec_t tbl[28];
    logic [5:0] rk;

    initial begin
        //          keys       tick  rst   chk   upd   dir    js    jh    jr
        tbl[0]  = '{6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{6'b001000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{6'b001000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{6'b000010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{6'b000010, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{6'b000011, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{6'b000011, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{6'b000010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{6'b000010, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{6'b000011, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{6'b000011, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{6'b000011, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{6'b000001, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[24] = '{6'b000001, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[25] = '{6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[26] = '{6'b000001, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[27] = '{6'b000001, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].k, tbl[i].t, tbl[i].r);
            if (tbl[i].c) begin
                chk($sformatf("tbl_upd[%0d]", i), {7'b0, upd}, {7'b0, tbl[i].upd});
                chk($sformatf("tbl_dir[%0d]", i), {6'b0, dir}, {6'b0, tbl[i].dir});
                chk($sformatf("tbl_js[%0d]", i), {7'b0, jump_start}, {7'b0, tbl[i].js});
                chk($sformatf("tbl_jh[%0d]", i), {7'b0, jump_hold}, {7'b0, tbl[i].jh});
                chk($sformatf("tbl_jr[%0d]", i), {7'b0, jump_release}, {7'b0, tbl[i].jr});
            end
        end

        // Shoot held for 40 frames: fires at 0, 20, 24, 28, 32, 36; no repeat when delay is 0.
        for (int f = 0; f < 40; f++) begin
            step(6'b000100, 1'b1, 1'b0);
            chk($sformatf("shoot_f%0d", f), {7'b0, shoot},
                {7'b0, (f == 0) || (f >= 20 && (f - 20) % 4 == 0)});
            chk($sformatf("nr_shoot_f%0d", f), {7'b0, shoot_nr}, {7'b0, f == 0});
            step(6'b000100, 1'b0, 1'b0);
        end
        for (int f = 0; f < 6; f++) begin
            step(6'b000000, 1'b1, 1'b0);
            chk($sformatf("shoot_rel%0d", f), {7'b0, shoot}, 8'd0);
        end

        // Restart: fires once on the 30th held tick, re-arms only after R is seen low.
        for (int rep = 0; rep < 2; rep++) begin
            for (int t = 1; t <= 40; t++) begin
                step(6'b010000, 1'b1, 1'b0);
                chk($sformatf("restart_r%0d_t%0d", rep, t), {7'b0, restart}, {7'b0, t == RF});
                step(6'b010000, 1'b0, 1'b0);
                chk($sformatf("restart_hold_r%0d_t%0d", rep, t), {7'b0, restart}, {7'b0, t == RF});
            end
            step(6'b000000, 1'b1, 1'b0);
            chk($sformatf("restart_low%0d", rep), {7'b0, restart}, 8'd0);
        end

        // Random key traffic; S and R toggle rarely so long holds occur.
        rk = 6'b0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, (b == 2 || b == 4) ? 60 : 12) == 0) rk[b] = ~rk[b];
            end
            step(rk, $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
